// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: IF and MEM requester handshakes plus the
// byte-wide synchronous RAM port.
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_cancel;
   logic                  if_done;
   logic [31:0]           if_data;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [2:0]            mem_len;
   logic [31:0]           mem_wdata;
   logic                  mem_done;
   logic [31:0]           mem_rdata;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_wr;
   logic [7:0]            ram_dout;
   logic [7:0]            ram_din;

   modport slave (
      input  if_req, if_addr, if_cancel,
      input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
      input  ram_din,
      output if_done, if_data, mem_done, mem_rdata,
      output ram_addr, ram_wr, ram_dout
   );

   modport master (
      output if_req, if_addr, if_cancel,
      output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
      output ram_din,
      input  if_done, if_data, mem_done, mem_rdata,
      input  ram_addr, ram_wr, ram_dout
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port arbiter serialising IF fetches and MEM loads/stores onto a
// byte-wide synchronous RAM, one byte per cycle, MEM having priority.
module mem_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            len_q, len_d;
   logic [2:0]            mem_len_dec;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic                  own_if_q, own_if_d;
   logic [31:0]           dbuf_q, dbuf_d;
   logic [1:0]            cap_sel;

   logic                  if_done_q, if_done_d;
   logic [31:0]           if_data_q, if_data_d;
   logic                  mem_done_q, mem_done_d;
   logic [31:0]           mem_rdata_q, mem_rdata_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic                  ram_wr_q, ram_wr_d;
   logic [7:0]            ram_dout_q, ram_dout_d;

   always_comb begin
      unique case (bus.mem_len)
         3'd1:    mem_len_dec = 3'd1;
         3'd2:    mem_len_dec = 3'd2;
         default: mem_len_dec = 3'd4;
      endcase
   end

   assign nxt_addr = addr_q + ADDR_WIDTH'(cnt_q);
   // In RD, cnt counts cycles since acceptance; the byte arriving now
   // was addressed two counts ago.
   assign cap_sel  = 2'(cnt_q - 3'd2);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      addr_d      = addr_q;
      own_if_d    = own_if_q;
      dbuf_d      = dbuf_q;
      if_done_d   = 1'b0;
      if_data_d   = if_data_q;
      mem_done_d  = 1'b0;
      mem_rdata_d = mem_rdata_q;
      ram_addr_d  = '0;
      ram_wr_d    = 1'b0;
      ram_dout_d  = 8'h00;

      unique case (state_q)
         IDLE: begin
            if (bus.mem_req) begin
               own_if_d   = 1'b0;
               addr_d     = bus.mem_addr;
               len_d      = mem_len_dec;
               cnt_d      = 3'd1;
               ram_addr_d = bus.mem_addr;
               if (bus.mem_we) begin
                  state_d    = WR;
                  dbuf_d     = bus.mem_wdata;
                  ram_wr_d   = 1'b1;
                  ram_dout_d = bus.mem_wdata[7:0];
               end else begin
                  state_d = RD;
                  dbuf_d  = '0;
               end
            end else if (bus.if_req && !bus.if_cancel) begin
               own_if_d   = 1'b1;
               addr_d     = bus.if_addr;
               len_d      = 3'd4;
               cnt_d      = 3'd1;
               ram_addr_d = bus.if_addr;
               state_d    = RD;
               dbuf_d     = '0;
            end
         end
         RD: begin
            if (own_if_q && bus.if_cancel) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q < len_q) ram_addr_d = nxt_addr;
               if (cnt_q >= 3'd2)
                  dbuf_d[{cap_sel, 3'b000} +: 8] = bus.ram_din;
               if (cnt_q == len_q + 3'd1) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  if (own_if_q) begin
                     if_done_d = 1'b1;
                     if_data_d = dbuf_d;
                  end else begin
                     mem_done_d  = 1'b1;
                     mem_rdata_d = dbuf_d;
                  end
               end
            end
         end
         WR: begin
            if (cnt_q < len_q) begin
               ram_wr_d   = 1'b1;
               ram_addr_d = nxt_addr;
               ram_dout_d = dbuf_q[{cnt_q[1:0], 3'b000} +: 8];
               cnt_d      = cnt_q + 3'd1;
            end else begin
               state_d    = DONE;
               cnt_d      = '0;
               mem_done_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         own_if_q    <= 1'b0;
         dbuf_q      <= '0;
         if_done_q   <= 1'b0;
         if_data_q   <= '0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= '0;
         ram_addr_q  <= '0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         own_if_q    <= own_if_d;
         dbuf_q      <= dbuf_d;
         if_done_q   <= if_done_d;
         if_data_q   <= if_data_d;
         mem_done_q  <= mem_done_d;
         mem_rdata_q <= mem_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
      end
   end

   assign bus.if_done   = if_done_q;
   assign bus.if_data   = if_data_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wr    = ram_wr_q;
   assign bus.ram_dout  = ram_dout_q;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller/arbiter shared by the instruction-fetch path (IF / i-cache) and the MEM stage of the 5-stage RISC-V pipeline. It serialises 32-bit instruction fetches and 1/2/4-byte loads and stores onto a byte-wide synchronous RAM bus, one byte per cycle. It returns completion pulses that the requesters use to drop their stall requests toward the pipeline stall controller. MEM-stage requests have priority over fetches, matching the pipeline's stall priority.

## Interface
- ADDR_WIDTH, 32, width of all address ports
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  fetch request, level, held until if_done
- if_addr  input  ADDR_WIDTH  fetch byte address
- if_cancel  input  1  abort in-flight fetch (jump/branch redirect)
- if_done  output  1  one-cycle pulse, if_data valid
- if_data  output  32  fetched word, little-endian
- mem_req  input  1  load/store request, level, held until mem_done
- mem_we  input  1  1 = store, 0 = load
- mem_addr  input  ADDR_WIDTH  load/store byte address
- mem_len  input  3  access size in bytes: 1, 2 or 4
- mem_wdata  input  32  store data, low mem_len bytes used
- mem_done  output  1  one-cycle pulse, access complete
- mem_rdata  output  32  load data, zero-extended (sign extension done in MEM stage)
- ram_addr  output  ADDR_WIDTH  RAM byte address
- ram_wr  output  1  RAM write enable
- ram_dout  output  8  RAM write byte
- ram_din  input  8  RAM read byte, valid one cycle after ram_addr presented

## Operation
- States: IDLE, RD, WR, DONE; 3-bit byte counter cnt; latched addr, len, owner (IF/MEM), data buffer.
- IDLE: if mem_req, accept MEM (RD if !mem_we, WR if mem_we); else if if_req and !if_cancel, accept IF (RD, len=4); else stay. Inputs latched at acceptance; later input changes ignored.
- Length decode: mem_len 1, 2, 4 legal; any other value treated as 4.
- RD, issue phase: for cnt = 0..len-1, ram_addr = addr+cnt, ram_wr = 0.
- RD, capture phase: ram_din captured into byte cnt-1 of buffer one cycle after each address; after last capture go DONE.
- WR: for cnt = 0..len-1, ram_wr = 1, ram_addr = addr+cnt, ram_dout = wdata byte cnt (byte 0 = bits 7:0); then DONE.
- DONE: assert owner's done for exactly one cycle with data; go IDLE. req not sampled in DONE; requester must deassert req by the cycle after done.
- Address arithmetic modulo 2^ADDR_WIDTH (addr+cnt wraps at 0xFFFFFFFF -> 0).
- Unused upper bytes of mem_rdata are 0.
- No preemption: a fetch in progress completes even if mem_req rises; MEM is served next.
- if_cancel while owner = IF in RD: next edge -> IDLE, buffer discarded, no if_done.
- if_cancel during a MEM transaction or in DONE: no effect.
- if_data / mem_rdata hold their last value outside done cycles.

## Timing
- Reset (async, any state): state IDLE, cnt 0; if_done, mem_done, ram_wr 0; ram_addr, ram_dout, if_data, mem_rdata 0. Mid-transaction reset produces no done.
- All outputs registered.
- Let cycle 0 = IDLE cycle in which the req is sampled:
  - Read of n bytes: ram_addr = A+i in cycle 1+i; done in cycle n+2 (fetch: cycle 6).
  - Write of n bytes: ram_wr = 1 in cycles 1..n; done in cycle n+1.
- Back-to-back: after done in cycle D, IDLE in D+1 can accept a new request; next ram activity in D+2.
- IDLE/DONE outputs: ram_wr 0, ram_addr 0, ram_dout 0.

## Test plan
- Fetch: RAM[0x100..0x103] = 13,05,A0,00; if_req at 0x100 -> ram_addr 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_data 0x00A00513.
- Simultaneous: if_req and mem_req (load, len 2, 0x200 = 34,12) in the same cycle -> MEM served first, mem_rdata 0x00001234; fetch starts the cycle after mem_done deasserts req.
- Store: mem_we, len 4, addr 0x300, wdata 0xDEADBEEF -> ram_wr high 4 cycles with bytes EF,BE,AD,DE at 0x300..0x303; mem_done in cycle 5; no if_done.
- Cancel: if_cancel asserted in cycle 3 of a fetch -> IDLE next edge, no if_done, next request accepted normally.
- Wrap/illegal length: load at 0xFFFFFFFF with mem_len = 3 -> treated as 4 bytes at 0xFFFFFFFF, 0x0, 0x1, 0x2.
- Reset: rst pulsed mid-store -> ram_wr 0 immediately, no mem_done, all outputs 0.
